// File: rtl/seri_mul_pkg.sv
// Shared definitions for the serial shift-add multiplier: FSM encoding and width helpers.
package seri_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } seri_state_t;

    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/seri_mul_dp.sv
// Serial multiplier datapath: accumulator, operand registers, one adder, shifter, final negator.
// Sign handling is present only when SERI_MUL_SIGNED_EN is defined.
module seri_mul_dp
    import seri_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       step,
    input  logic                       finish,
    input  logic [WIDTH-1:0]           op_a,
    input  logic [WIDTH-1:0]           op_b,
`ifdef SERI_MUL_SIGNED_EN
    input  logic                       sgn_mode,
`endif
    output logic [prod_w(WIDTH)-1:0]   result
);

    localparam int PW = prod_w(WIDTH);

    logic [PW:0]      acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

`ifdef SERI_MUL_SIGNED_EN
    logic neg;

    // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
    assign mag_a = (sgn_mode && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    assign mag_b = (sgn_mode && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
    assign result = !finish ? '0 :
                    neg     ? (~acc[PW-1:0] + 1'b1) : acc[PW-1:0];
`else
    assign mag_a  = op_a;
    assign mag_b  = op_b;
    assign result = finish ? acc[PW-1:0] : '0;
`endif

    assign sum = acc[PW:WIDTH] + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
`ifdef SERI_MUL_SIGNED_EN
            neg    <= 1'b0;
`endif
        end else if (load) begin
            acc    <= '0;
            mcand  <= mag_a;
            mplier <= mag_b;
`ifdef SERI_MUL_SIGNED_EN
            neg    <= sgn_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`endif
        end else if (step) begin
            acc    <= {1'b0, sum, acc[WIDTH-1:1]};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seri_mul_gen.sv
// Parametrised serial shift-add multiplier top: FSM, step counter and output registers.
// Signed operation is available when SERI_MUL_SIGNED_EN is defined; otherwise sgn_mode is ignored.
module seri_mul_gen
    import seri_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     mul_a,
    input  logic [WIDTH-1:0]     mul_b,
    input  logic                 sgn_mode,
    input  logic                 en_mul,
    output logic [2*WIDTH-1:0]   product,
    output logic                 op_done,
    output logic                 busy
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    seri_state_t                state;
    logic [CW-1:0]              cnt;
    logic                       dp_load;
    logic                       dp_step;
    logic                       dp_fin;
    logic [prod_w(WIDTH)-1:0]   dp_result;

    assign dp_load = (state == ST_IDLE) && en_mul;
    assign dp_step = (state == ST_CALC);
    assign dp_fin  = (state == ST_FIN);

`ifndef SERI_MUL_SIGNED_EN
    logic sgn_unused;
    assign sgn_unused = sgn_mode;
`endif

    seri_mul_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (dp_load),
        .step     (dp_step),
        .finish   (dp_fin),
        .op_a     (mul_a),
        .op_b     (mul_b),
`ifdef SERI_MUL_SIGNED_EN
        .sgn_mode (sgn_mode),
`endif
        .result   (dp_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            product <= '0;
            op_done <= 1'b0;
            busy    <= 1'b0;
        end else begin
            op_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en_mul) begin
                        state <= ST_CALC;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) state <= ST_FIN;
                end
                ST_FIN: begin
                    product <= dp_result;
                    op_done <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
